// File: rtl/udsched_pkg.sv
// udsched_pkg: shared definitions for the up/down counter job scheduler.
//   state_t  - scheduler FSM encoding (IDLE / RUN / DONE)
//   id_width - width of a requester id for a given requester count
package udsched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single requester still needs one id bit so ports never collapse to zero width.
  function automatic int unsigned id_width(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/udsched_rr_pick.sv
// udsched_rr_pick: combinational round-robin picker.
// Searches req starting at last_grant+1 and wrapping modulo NREQ; the first
// set bit wins.
//   req        in   NREQ  request vector
//   last_grant in   IDW   index granted most recently
//   any        out  1     at least one request is set
//   winner     out  IDW   index of the winning request (0 when any = 0)
module udsched_rr_pick
  import udsched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  // One extra bit so last_grant + offset cannot overflow before the modulo fold.
  logic [IDW:0] cand;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_grant} + (IDW+1)'(i);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!any && req[cand[IDW-1:0]]) begin
        any    = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/updown_cnt_sched.sv
// updown_cnt_sched: round-robin scheduler sharing one up/down counter among
// NREQ requesters. A job (direction + step count) is accepted in IDLE, the
// counter is enabled for exactly that many clocks, then a one-cycle done pulse
// reports the owner id and the resulting counter value.
//
// Ports:
//   clock, reset              rising-edge clock; asynchronous active-low reset
//   req_valid/req_up          per-requester job valid and direction (1 = up)
//   req_steps                 per-requester step count, requester i at [i*STEPW +: STEPW]
//   req_ready                 one-hot accept strobe (combinational, IDLE only)
//   cnt_en, cnt_up            drive the shared counter's enable and direction
//   cnt_value                 current shared counter value
//   busy                      job in progress (RUN or DONE)
//   grant_id                  id of the job currently owned
//   done, done_id, done_value completion pulse, owner id, sampled counter value
//
// Build option UDSCHED_ABORT_EN adds input abort (ends a running job early,
// cnt_en forced low in the abort cycle) and output done_aborted.
module updown_cnt_sched
  import udsched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned STEPW = 4,
  parameter int unsigned CNTW  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_up,
  input  logic [NREQ*STEPW-1:0]     req_steps,
  output logic [NREQ-1:0]           req_ready,
  output logic                      cnt_en,
  output logic                      cnt_up,
  input  logic [CNTW-1:0]           cnt_value,
  output logic                      busy,
  output logic [id_width(NREQ)-1:0] grant_id,
  output logic                      done,
  output logic [id_width(NREQ)-1:0] done_id,
  output logic [CNTW-1:0]           done_value
`ifdef UDSCHED_ABORT_EN
  ,
  input  logic                      abort,
  output logic                      done_aborted
`endif
);

  localparam int unsigned IDW = id_width(NREQ);

  state_t           state, state_nxt;
  logic             up_q;
  logic [STEPW-1:0] rem_q;
  logic [IDW-1:0]   last_grant;

  logic             pick_any;
  logic [IDW-1:0]   pick_id;
  logic             sel_up;
  logic [STEPW-1:0] sel_steps;
  logic             accept;
  logic             abort_run;

  udsched_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .any        (pick_any),
    .winner     (pick_id)
  );

  // Select the winning requester's job fields.
  always_comb begin
    sel_up    = 1'b0;
    sel_steps = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_id == IDW'(i)) begin
        sel_up    = req_up[i];
        sel_steps = req_steps[i*STEPW +: STEPW];
      end
    end
  end

`ifdef UDSCHED_ABORT_EN
  logic aborted_q;

  always_comb begin
    abort_run    = (state == RUN) && abort;
    done_aborted = (state == DONE) && aborted_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aborted_q <= 1'b0;
    end else if (accept) begin
      aborted_q <= 1'b0;
    end else if (abort_run) begin
      aborted_q <= 1'b1;
    end
  end
`else
  always_comb begin
    abort_run = 1'b0;
  end
`endif

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req_ready  = '0;
    cnt_en     = 1'b0;
    cnt_up     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    done_id    = '0;
    done_value = '0;
    unique case (state)
      IDLE: begin
        // Gating on reset keeps req_ready at 0 while reset is held.
        if (pick_any && reset) begin
          accept             = 1'b1;
          req_ready[pick_id] = 1'b1;
          state_nxt          = (sel_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy   = 1'b1;
        cnt_up = up_q;
        cnt_en = !abort_run;
        // Leaving when one step remains gives exactly 'steps' enabled cycles.
        if (abort_run || rem_q == STEPW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        cnt_up     = up_q;
        done       = 1'b1;
        done_id    = grant_id;
        done_value = cnt_value;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      up_q       <= 1'b0;
      rem_q      <= '0;
      grant_id   <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      state <= state_nxt;
      if (accept) begin
        up_q       <= sel_up;
        rem_q      <= sel_steps;
        grant_id   <= pick_id;
        last_grant <= pick_id;
      end else if (state == RUN) begin
        rem_q <= rem_q - STEPW'(1);
      end
    end
  end

endmodule

// File: doc/updown_cnt_sched.md
Name: updown_cnt_sched

Overview:
- Scheduler that shares one 4-bit up/down counter, with count-enable, among NREQ requesters.
- Each requester submits a job: direction plus step count. The block round-robin arbitrates, then drives the counter's enable and direction for exactly that many clocks.
- On completion it reports the requester id and the resulting count value.
- Sits between the client FSMs and the shared counter instance; it is the only driver of the counter's enable and direction inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- STEPW, 4, width of a job's step count (0..2^STEPW-1 steps).
- CNTW, 4, width of the shared counter value.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; reset reset, asynchronous, active-low; clock clock.
- req_valid  in  NREQ  per-requester job valid.
- req_up  in  NREQ  per-requester direction (1 = up, 0 = down).
- req_steps  in  NREQ*STEPW  per-requester step count; requester i occupies bits [i*STEPW +: STEPW].
- req_ready  out  NREQ  one-hot accept strobe; a job transfers on req_valid[i] & req_ready[i].
- cnt_en  out  1  counter enable; the counter advances one step per clock while high.
- cnt_up  out  1  counter direction.
- cnt_value  in  CNTW  current value of the shared counter.
- busy  out  1  a job is in progress (state RUN or DONE).
- grant_id  out  $clog2(NREQ)  id of the job currently owned.
- done  out  1  one-cycle completion pulse.
- done_id  out  $clog2(NREQ)  id of the completed job; valid while done = 1.
- done_value  out  CNTW  cnt_value sampled in the DONE cycle.

Behaviour:
- Reset values: state IDLE; all outputs 0; last_grant = NREQ-1, so requester 0 has first priority.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req_valid is set, pick the first valid index searching last_grant+1, +2, … modulo NREQ.
  - Assert req_ready for the winner, combinationally in the same cycle; req_ready is 0 for all others.
  - At the clock edge: capture up and steps, set grant_id = winner and last_grant = winner.
  - Next state is RUN if steps != 0, otherwise DONE.
- RUN:
  - cnt_en = 1; cnt_up = captured direction.
  - Internal remaining counter loads with steps and decrements each cycle.
  - Leave for DONE on the edge where remaining = 1, so cnt_en is high for exactly steps cycles.
- DONE:
  - done = 1; done_id = grant_id; done_value = cnt_value, which already reflects the last step.
  - cnt_en = 0. Next state is IDLE.
- busy = 1 in RUN and DONE.
- Timing: no request is accepted in RUN or DONE. Job turnaround is 1 (accept) + steps + 1 (done) cycles. The earliest next accept is the cycle after DONE.
- Wrap-around is the counter's behaviour, not the scheduler's: 15 up one step gives 0; 0 down one step gives 15. The scheduler does no range checking.
- Requesters must hold req_valid, req_up and req_steps stable until accepted. Changes after acceptance have no effect on the running job.
- Simultaneous requests: strict round-robin. No requester is granted twice while another valid requester waits.
- cnt_up is held at the captured direction through DONE, then returns to 0 in IDLE.
- Reset asserted mid-job: immediate return to IDLE. cnt_en drops asynchronously; the job is lost with no done pulse.

Optional Feature:
- Macro: UDSCHED_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit) and output done_aborted (1 bit, reset 0).
  - abort = 1 in RUN: cnt_en is forced 0 in that same cycle, and the next state is DONE with done_aborted = 1.
  - abort in IDLE or DONE is ignored.
- Undefined: both ports are absent; done_aborted is implicitly 0.

Decomposition:
- Package udsched_pkg holds:
  - the state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - an id-width function clog2-based on NREQ.
- One sub-module: udsched_rr_pick.
  - Purely combinational round-robin picker.
  - Inputs: req vector, last_grant. Outputs: any, winner index.

Test Plan:
1. Reset, then req_valid[0] = 1, up = 1, steps = 3, cnt_value starting at 0:
   - req_ready[0] pulses for 1 cycle;
   - cnt_en high for exactly 3 cycles with cnt_up = 1;
   - done pulse with done_id = 0, done_value = 3.
2. Counter at 1; req 2 down with steps = 2:
   - done_value = 15 (wrap);
   - turnaround is 4 cycles from accept to done.
3. steps = 0:
   - accept followed directly by DONE; cnt_en never asserts; done_value = current count.
4. All four requesters hold req_valid continuously with steps = 1:
   - grant order is 0, 1, 2, 3, 0; a new accept comes every 3 cycles.
5. Assert reset mid-RUN (after 2 of 5 steps):
   - cnt_en = 0 and state IDLE immediately; no done pulse;
   - next grant goes to requester 0.
6. UDSCHED_ABORT_EN defined; abort in the second RUN cycle of a 5-step job:
   - cnt_en is high for 1 cycle only;
   - done = 1 with done_aborted = 1.
